// File: rtl/mapping_frame_sequencer.sv
// Crate mapping sequencer: arms on the fiber header word, strobes FRAMES indexed loads,
// then publishes (done) and clears the datapath; tracks header tag and resync/drop counts.
module mapping_frame_sequencer #(
    parameter logic [15:0] HEADER_WORD = 16'hAAAA,
    parameter int          FRAMES      = 16,
    parameter int          IDX_W       = 5,
    parameter bit          RESYNC      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [24:0]      fiber_i,
    input  logic             enable_i,
    output logic             busy_o,
    output logic             frame_valid_o,
    output logic [IDX_W-1:0] frame_idx_o,
    output logic             done_o,
    output logic             clr_o,
    output logic [8:0]       hdr_tag_o,
    output logic [7:0]       resync_cnt_o,
    output logic [7:0]       drop_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_CLEAR} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAMES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [8:0]       tag_q, tag_d;
    logic [7:0]       resync_q, resync_d;
    logic [7:0]       drop_q, drop_d;
    logic             busy_q, busy_d;
    logic             fv_q, fv_d;
    logic             done_q, done_d;
    logic             clr_q, clr_d;
    logic             hdr_match;
    logic             resync_now;

    assign hdr_match  = (fiber_i[15:0] == HEADER_WORD);
    assign resync_now = RESYNC && (state_q == S_CAPTURE) && hdr_match;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tag_q    <= '0;
            resync_q <= '0;
            drop_q   <= '0;
            busy_q   <= 1'b0;
            fv_q     <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            resync_q <= resync_d;
            drop_q   <= drop_d;
            busy_q   <= busy_d;
            fv_q     <= fv_d;
            done_q   <= done_d;
            clr_q    <= clr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tag_d    = tag_q;
        resync_d = resync_q;
        drop_d   = drop_q;
        unique case (state_q)
            S_IDLE: begin
                if (enable_i && hdr_match) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                    tag_d   = fiber_i[24:16];
                end
            end
            S_CAPTURE: begin
                if (resync_now) begin
                    cnt_d    = '0;
                    tag_d    = fiber_i[24:16];
                    resync_d = (resync_q == 8'hFF) ? resync_q : resync_q + 8'd1;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE, S_CLEAR: begin
                state_d = (state_q == S_DONE) ? S_CLEAR : S_IDLE;
                if (hdr_match) begin
                    drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state so they line up with the state being entered.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        fv_d   = (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
        clr_d  = (state_d == S_CLEAR);
    end

    // A header arriving mid-capture must not be loaded as data: it suppresses the strobe and
    // clears the datapath in the very cycle the header word sits on the fiber.
    assign frame_valid_o = fv_q & ~resync_now;
    assign clr_o         = clr_q | resync_now;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign frame_idx_o   = cnt_q;
    assign hdr_tag_o     = tag_q;
    assign resync_cnt_o  = resync_q;
    assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_mapping_frame_sequencer.sv
// Scoreboard bench: a packet-level scan of the stimulus stream predicts every strobe/done/clr
// event; a negedge monitor pops and compares them as the DUT emits them.
module tb_mapping_frame_sequencer;

    localparam int FRAMES = 16;
    localparam int T      = 1800;
    localparam int N      = T + 40;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [24:0] fiber_i = '0;
    logic        enable_i = 1'b0;
    logic        busy_o, frame_valid_o, done_o, clr_o;
    logic [4:0]  frame_idx_o;
    logic [8:0]  hdr_tag_o;
    logic [7:0]  resync_cnt_o, drop_cnt_o;

    mapping_frame_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .fiber_i(fiber_i), .enable_i(enable_i),
        .busy_o(busy_o), .frame_valid_o(frame_valid_o), .frame_idx_o(frame_idx_o),
        .done_o(done_o), .clr_o(clr_o), .hdr_tag_o(hdr_tag_o),
        .resync_cnt_o(resync_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int         cyc;
        logic [2:0] bits;   // {frame_valid, done, clr}
        int         idx;
        int         tag;
    } ev_t;

    ev_t         exp_q[$];
    logic [24:0] fib [N];
    bit          en [N];
    bit          exp_busy [N];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          exp_resync = 0, exp_drop = 0;
    int          first_done = -1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [24:0] rnd_data();
        logic [24:0] v;
        v = 25'($urandom);
        if (v[15:0] == 16'hAAAA) v[0] = ~v[0];
        return v;
    endfunction

    function automatic logic [24:0] hdr_word(input int tag);
        logic [8:0] t9;
        t9 = tag[8:0];
        return {t9, 16'hAAAA};
    endfunction

    function automatic bit is_hdr(input int t);
        if (t >= N) return 1'b0;
        return fib[t][15:0] == 16'hAAAA;
    endfunction

    function automatic int tag_of(input int t);
        return int'(fib[t][24:16]);
    endfunction

    function automatic void push(input int c, input logic [2:0] b, input int idx, input int tag);
        ev_t e;
        e.cyc = c; e.bits = b; e.idx = idx; e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Walks the input stream a packet at a time: accept, frames until FRAMES done or a
    // restarting header, then done, clear, and the drop window.
    task automatic build_model();
        int t, s, tag, c;
        bit restarted;
        t = 0;
        while (t < N) begin
            if (en[t] && is_hdr(t)) begin
                s = t;
                tag = tag_of(t);
                do begin
                    restarted = 1'b0;
                    for (int j = 1; j <= FRAMES; j++) begin
                        c = s + j;
                        exp_busy[c] = 1'b1;
                        if (is_hdr(c)) begin
                            push(c, 3'b001, 0, tag);
                            if (exp_resync < 255) exp_resync++;
                            tag = tag_of(c);
                            s = c;
                            restarted = 1'b1;
                            break;
                        end
                        push(c, 3'b100, j - 1, tag);
                    end
                end while (restarted);
                push(s + FRAMES + 1, 3'b010, 0, tag);
                push(s + FRAMES + 2, 3'b001, 0, tag);
                exp_busy[s + FRAMES + 1] = 1'b1;
                exp_busy[s + FRAMES + 2] = 1'b1;
                for (int k = 1; k <= 2; k++)
                    if (is_hdr(s + FRAMES + k) && exp_drop < 255) exp_drop++;
                t = s + FRAMES + 3;
            end else begin
                t++;
            end
        end
    endtask

    always @(negedge clk_i) begin : monitor
        logic [2:0] b;
        ev_t e;
        if (mon_en) begin
            b = {frame_valid_o, done_o, clr_o};
            chk("busy", longint'(busy_o), longint'(exp_busy[cyc]));
            if (done_o && first_done < 0) first_done = cyc;
            if (b != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", longint'(b), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_cycle", cyc, e.cyc);
                    chk("event_kind", longint'(b), longint'(e.bits));
                    if (e.bits == 3'b100) chk("frame_idx", longint'(frame_idx_o), e.idx);
                    if (e.bits != 3'b001) chk("hdr_tag", longint'(hdr_tag_o), e.tag);
                end
            end
        end
    end

    function automatic longint out_vec();
        return longint'({busy_o, frame_valid_o, frame_idx_o, done_o, clr_o,
                         hdr_tag_o, resync_cnt_o, drop_cnt_o});
    endfunction

    initial begin
        int pulses;

        repeat (3) @(posedge clk_i);
        #1 chk("reset_outputs", out_vec(), 0);
        @(negedge clk_i) rst_i = 1'b0;

        for (int t = 0; t < N; t++) begin
            fib[t] = rnd_data();
            en[t]  = (t < T) ? ($urandom_range(3) != 0) : 1'b0;
            exp_busy[t] = 1'b0;
        end
        en[10] = 1'b1;  fib[10] = hdr_word(9'h1A5);
        en[40] = 1'b0;  fib[40] = hdr_word(9'h033);
        en[41] = 1'b1;  fib[41] = hdr_word(9'h044);
        en[80] = 1'b1;  fib[80] = hdr_word(9'h0AB);
        fib[86] = hdr_word(9'h0CD);
        en[120] = 1'b1; fib[120] = hdr_word(9'h111);
        fib[137] = hdr_word(9'h122);
        fib[138] = hdr_word(9'h133);
        en[139] = 1'b1; fib[139] = hdr_word(9'h144);
        en[170] = 1'b1; fib[170] = hdr_word(9'h155);
        fib[186] = hdr_word(9'h166);
        for (int t = 200; t < T; t++)
            if ($urandom_range(7) == 0) fib[t] = hdr_word(int'($urandom_range(511)));
        build_model();

        for (int t = 0; t < N; t++) begin
            @(posedge clk_i);
            #1;
            fiber_i  = fib[t];
            enable_i = en[t];
            cyc      = t;
            mon_en   = 1'b1;
        end
        @(negedge clk_i);
        #1 mon_en = 1'b0;
        chk("events_left_over", exp_q.size(), 0);
        chk("first_done_cycle", first_done, 27);
        chk("resync_cnt", longint'(resync_cnt_o), exp_resync);
        chk("drop_cnt", longint'(drop_cnt_o), exp_drop);

        // Asynchronous reset in the middle of a capture.
        @(posedge clk_i);
        #1 fiber_i = hdr_word(9'h0F0); enable_i = 1'b1;
        repeat (8) begin
            @(posedge clk_i);
            #1 fiber_i = rnd_data();
        end
        @(negedge clk_i);
        #2 rst_i = 1'b1;
        #1 chk("async_reset_outputs", out_vec(), 0);
        @(negedge clk_i) rst_i = 1'b0;
        pulses = 0;
        repeat (25) begin
            @(negedge clk_i);
            if (done_o || clr_o || frame_valid_o || busy_o) pulses++;
        end
        chk("activity_after_reset", pulses, 0);

        // 1 accept followed by 300 back-to-back restarts.
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 301; i++) begin
            fiber_i = hdr_word(i);
            @(posedge clk_i);
            #1;
        end
        fiber_i = rnd_data();
        repeat (20) @(posedge clk_i);
        #1;
        chk("resync_saturated", longint'(resync_cnt_o), 255);
        chk("drop_after_reset", longint'(drop_cnt_o), 0);
        chk("idle_after_saturation", longint'(busy_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
